// File: rtl/ad1939_spi_config_sequencer_if.sv
// rtl/ad1939_spi_config_sequencer_if.sv - host and codec pin bundle for the AD1939 SPI config sequencer
interface ad1939_spi_config_sequencer_if;
    // Host control side
    logic       start;
    logic       cfg_wr_en;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_wr_data;
    logic       busy;
    logic       done;
    logic       error;
    logic       pll_locked;
    logic [7:0] rd_data;
    // Codec control port pins
    logic       cclk;
    logic       clatch_n;
    logic       cin;
    logic       cout;

    // Sequencer view: takes host commands and the codec's COUT, drives everything else
    modport slave (
        input  start, cfg_wr_en, cfg_addr, cfg_wr_data, cout,
        output busy, done, error, pll_locked, rd_data, cclk, clatch_n, cin
    );

    // Host/codec view
    modport master (
        output start, cfg_wr_en, cfg_addr, cfg_wr_data, cout,
        input  busy, done, error, pll_locked, rd_data, cclk, clatch_n, cin
    );
endinterface

// File: rtl/ad1939_spi_config_sequencer.sv
// rtl/ad1939_spi_config_sequencer.sv - AD1939 shadow-register writer and PLL-lock poller over SPI
module ad1939_spi_config_sequencer #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned NUM_REGS      = 17,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter int unsigned POLL_MAX      = 64,
    parameter logic [6:0]  CHIP_ADDR     = 7'b0000100
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    ad1939_spi_config_sequencer_if.slave        bus_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_POLL_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] POLL_LAST  = 16'(POLL_INTERVAL - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
    localparam logic [5:0]  NUM_REGS_W = 6'(NUM_REGS);
    localparam logic [4:0]  LAST_REG   = 5'(NUM_REGS - 1);
    // PLL and clock control 1 holds the lock flag in bit 3
    localparam logic [4:0]  PLL_REG    = 5'd1;
    localparam logic [4:0]  LAST_BIT   = 5'd23;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] shreg_q, shreg_d;
    logic        is_read_q, is_read_d;
    logic [7:0]  rx_q, rx_d;
    logic        cclk_q, cclk_d;
    logic        clatch_n_q, clatch_n_d;
    logic        cin_q, cin_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        pll_locked_q, pll_locked_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [7:0]  shadow_q [NUM_REGS];

    logic        load_go;
    logic        load_rd;
    logic [4:0]  load_addr;
    logic [7:0]  load_data;

    // Host shadow writes, accepted in every state; out-of-range addresses are dropped
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if (bus_if.cfg_wr_en && ({1'b0, bus_if.cfg_addr} < NUM_REGS_W)) begin
            shadow_q[bus_if.cfg_addr] <= bus_if.cfg_wr_data;
        end
    end

    // Address of the frame that would be loaded next, derived only from current state
    always_comb begin
        load_addr = PLL_REG;
        if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
            load_addr = 5'd0;
        end else if (!is_read_q && idx_q != LAST_REG) begin
            load_addr = idx_q + 5'd1;
        end
    end

    // Shadow data for that frame, forwarding a write that lands on the same edge as the load
    always_comb begin
        load_data = shadow_q[load_addr];
        if (bus_if.cfg_wr_en && bus_if.cfg_addr == load_addr) begin
            load_data = bus_if.cfg_wr_data;
        end
    end

    // Sequencer next-state, SPI bit engine and status outputs
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        poll_cnt_d   = poll_cnt_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        is_read_d    = is_read_q;
        rx_d         = rx_q;
        cclk_d       = cclk_q;
        clatch_n_d   = clatch_n_q;
        cin_d        = cin_q;
        rd_data_d    = rd_data_q;
        pll_locked_d = pll_locked_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        load_go      = 1'b0;
        load_rd      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus_if.start) begin
                    load_go = 1'b1;
                    idx_d   = 5'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end

            S_LOAD: begin
                state_d = S_SHIFT;
                div_d   = 8'd0;
                bit_d   = 5'd0;
            end

            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (!cclk_q) begin
                        // Rising CCLK: codec output is captured on the same clk edge
                        cclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], bus_if.cout};
                    end else begin
                        cclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            clatch_n_d = 1'b1;
                            cin_d      = 1'b0;
                            cnt_d      = 16'd0;
                            state_d    = S_GAP;
                            if (is_read_q) begin
                                rd_data_d    = rx_q;
                                pll_locked_d = rx_q[3];
                            end
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            cin_d   = shreg_q[22];
                            shreg_d = {shreg_q[22:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (!is_read_q && idx_q != LAST_REG) begin
                        idx_d   = load_addr;
                        load_go = 1'b1;
                    end else if (!is_read_q) begin
                        load_go    = 1'b1;
                        load_rd    = 1'b1;
                        poll_cnt_d = 16'd1;
                    end else if (pll_locked_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (poll_cnt_q == POLL_LIMIT) begin
                        state_d = S_ERR;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_POLL_WAIT;
                        cnt_d   = 16'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_POLL_WAIT: begin
                if (cnt_q == POLL_LAST) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    load_go    = 1'b1;
                    load_rd    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering LOAD latches the whole frame and opens the latch with bit 23 already on CIN
        if (load_go) begin
            state_d    = S_LOAD;
            is_read_d  = load_rd;
            shreg_d    = {CHIP_ADDR, load_rd, 3'b000, load_addr, (load_rd ? 8'h00 : load_data)};
            cin_d      = shreg_d[23];
            clatch_n_d = 1'b0;
            cclk_d     = 1'b0;
        end
    end

    // State and datapath registers; reset releases the latch at once, aborting any frame
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
            poll_cnt_q   <= 16'd0;
            cnt_q        <= 16'd0;
            div_q        <= 8'd0;
            bit_q        <= 5'd0;
            shreg_q      <= 24'd0;
            is_read_q    <= 1'b0;
            rx_q         <= 8'd0;
            cclk_q       <= 1'b0;
            clatch_n_q   <= 1'b1;
            cin_q        <= 1'b0;
            rd_data_q    <= 8'd0;
            pll_locked_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            poll_cnt_q   <= poll_cnt_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            is_read_q    <= is_read_d;
            rx_q         <= rx_d;
            cclk_q       <= cclk_d;
            clatch_n_q   <= clatch_n_d;
            cin_q        <= cin_d;
            rd_data_q    <= rd_data_d;
            pll_locked_q <= pll_locked_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus_if.cclk       = cclk_q;
    assign bus_if.clatch_n   = clatch_n_q;
    assign bus_if.cin        = cin_q;
    assign bus_if.busy       = busy_q;
    assign bus_if.done       = done_q;
    assign bus_if.error      = error_q;
    assign bus_if.pll_locked = pll_locked_q;
    assign bus_if.rd_data    = rd_data_q;

endmodule

// File: tb/tb_ad1939_spi_config_sequencer.sv
// tb/tb_ad1939_spi_config_sequencer.sv - directed table-driven bench for the AD1939 SPI config sequencer
module tb_ad1939_spi_config_sequencer;

    localparam int CLK_DIV       = 2;
    localparam int NUM_REGS      = 17;
    localparam int GAP_CYCLES    = 8;
    localparam int POLL_INTERVAL = 100;
    localparam int POLL_MAX      = 4;
    localparam int FRAME_LOW     = 48 * CLK_DIV + 1;
    localparam int WAIT_LIMIT    = 8000;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_vec_t;

    typedef struct {
        logic [23:0] word;
        int          low;
        int          gap;
    } frame_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ad1939_spi_config_sequencer_if bus ();

    ad1939_spi_config_sequencer #(
        .CLK_DIV       (CLK_DIV),
        .NUM_REGS      (NUM_REGS),
        .GAP_CYCLES    (GAP_CYCLES),
        .POLL_INTERVAL (POLL_INTERVAL),
        .POLL_MAX      (POLL_MAX),
        .CHIP_ADDR     (7'b0000100)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus_if  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  shadow_m [NUM_REGS];
    logic [23:0] fr_word  [256];
    int          fr_bits  [256];
    int          fr_start [256];
    int          fr_end   [256];
    int          nfr       = 0;
    int          nreads    = 0;
    int          zero_until = 0;
    int          cyc       = 0;
    int          proto_err = 0;

    // Codec model: captures frames, answers reads, watches pin-ordering rules
    logic        prev_cl = 1'b1, prev_cclk = 1'b0, prev_cin = 1'b0;
    logic        in_frame = 1'b0, rw = 1'b0;
    logic [23:0] word = '0;
    logic [7:0]  resp;
    int          bitn = 0, st = 0;
    always @(negedge clk) begin
        cyc++;
        if (bus.clatch_n === 1'b1 && prev_cl === 1'b1 && bus.cclk !== prev_cclk) proto_err++;
        if ((bus.cin !== prev_cin || bus.clatch_n !== prev_cl) && prev_cclk === 1'b1 && bus.cclk === 1'b1)
            proto_err++;
        if (prev_cl && !bus.clatch_n) begin
            in_frame = 1'b1; bitn = 0; word = '0; rw = 1'b0; st = cyc;
        end
        if (!prev_cl && bus.clatch_n && in_frame) begin
            if (nfr < 256) begin
                fr_word[nfr] = word; fr_bits[nfr] = bitn; fr_start[nfr] = st; fr_end[nfr] = cyc;
                nfr++;
            end
            if (bitn == 24 && rw) nreads++;
            in_frame = 1'b0;
            bus.cout = 1'b0;
        end
        if (!bus.clatch_n && !prev_cclk && bus.cclk) begin
            word = {word[22:0], bus.cin};
            if (bitn == 7) rw = bus.cin;
            bitn++;
        end
        if (!bus.clatch_n && prev_cclk && !bus.cclk) begin
            resp = (nreads < zero_until) ? 8'h00 : 8'h08;
            bus.cout = (rw && bitn >= 16 && bitn < 24) ? resp[23 - bitn] : 1'b0;
        end
        prev_cl = bus.clatch_n; prev_cclk = bus.cclk; prev_cin = bus.cin;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [7:0] data);
        bus.cfg_wr_en = 1'b1; bus.cfg_addr = addr; bus.cfg_wr_data = data;
        if (int'(addr) < NUM_REGS) shadow_m[addr] = data;
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(bus.done || bus.error) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < WAIT_LIMIT), 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_frame(input string name, input int idx, input logic need_cclk_hi);
        int n = 0;
        while (!(nfr == idx && !bus.clatch_n && (!need_cclk_hi || bus.cclk)) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < WAIT_LIMIT), 1'b1);
    endtask

    // Build the expected frame table from the shadow model and compare captured frames
    task automatic check_seq(input string name, input int base, input int n_rd);
        frame_exp_t tbl [32];
        int n_exp = NUM_REGS + n_rd;
        for (int i = 0; i < NUM_REGS; i++) begin
            tbl[i].word = {8'h08, 3'b000, 5'(i), shadow_m[i]};
            tbl[i].low  = FRAME_LOW;
            tbl[i].gap  = GAP_CYCLES;
        end
        for (int i = 0; i < n_rd; i++) begin
            tbl[NUM_REGS + i].word = 24'h09_01_00;
            tbl[NUM_REGS + i].low  = FRAME_LOW;
            tbl[NUM_REGS + i].gap  = (i == 0) ? GAP_CYCLES : GAP_CYCLES + POLL_INTERVAL;
        end
        check({name, "_count"}, nfr - base, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (base + i < nfr) begin
                check($sformatf("%s_word%0d", name, i), fr_word[base + i], tbl[i].word);
                check($sformatf("%s_low%0d", name, i), fr_end[base + i] - fr_start[base + i], tbl[i].low);
                if (i > 0)
                    check($sformatf("%s_gap%0d", name, i),
                          fr_start[base + i] - fr_end[base + i - 1], tbl[i].gap);
            end
        end
    endtask

    task automatic check_status(input string name, input logic b, input logic d, input logic e,
                                input logic pl, input logic [7:0] rd);
        check({name, "_busy"}, bus.busy, b);
        check({name, "_done"}, bus.done, d);
        check({name, "_error"}, bus.error, e);
        check({name, "_pll_locked"}, bus.pll_locked, pl);
        check({name, "_rd_data"}, bus.rd_data, rd);
    endtask

    initial begin
        wr_vec_t wr_tbl [4];
        int base;
        int dev;

        wr_tbl[0] = '{5'd2,  8'hA5};
        wr_tbl[1] = '{5'd0,  8'h11};
        wr_tbl[2] = '{5'd16, 8'hEE};
        wr_tbl[3] = '{5'd9,  8'h5C};

        for (int i = 0; i < NUM_REGS; i++) shadow_m[i] = 8'h00;
        bus.start = 1'b0; bus.cfg_wr_en = 1'b0; bus.cfg_addr = '0; bus.cfg_wr_data = '0; bus.cout = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values, then a long idle stretch with no start
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_cclk", bus.cclk, 1'b0);
        check("reset_clatch_n", bus.clatch_n, 1'b1);
        check("reset_cin", bus.cin, 1'b0);
        dev = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.cclk !== 1'b0 || bus.clatch_n !== 1'b1 || bus.cin !== 1'b0 || bus.busy !== 1'b0 ||
                bus.done !== 1'b0 || bus.error !== 1'b0 || bus.pll_locked !== 1'b0 || bus.rd_data !== 8'h00)
                dev++;
        end
        check("idle_hold", dev, 0);
        check("idle_no_frames", nfr, 0);

        // Full sequence, lock on the first poll
        foreach (wr_tbl[i]) cfg_write(wr_tbl[i].addr, wr_tbl[i].data);
        zero_until = nreads;
        base = nfr;
        pulse_start();
        check("seq1_busy_after_start", bus.busy, 1'b1);
        wait_end("seq1_timeout");
        check_seq("seq1", base, 1);
        check("seq1_frame2", fr_word[base + 2], 24'h08_02_A5);
        check_status("seq1_end", 1'b0, 1'b1, 1'b0, 1'b1, 8'h08);

        // Three unlocked polls, lock on the fourth
        zero_until = nreads + 3;
        base = nfr;
        pulse_start();
        wait_end("seq2_timeout");
        check_seq("seq2", base, 4);
        check_status("seq2_end", 1'b0, 1'b1, 1'b0, 1'b1, 8'h08);

        // Never locks: POLL_MAX reads then error
        zero_until = nreads + 1000;
        base = nfr;
        pulse_start();
        wait_end("seq3_timeout");
        check_seq("seq3", base, POLL_MAX);
        check_status("seq3_end", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Restart from ERR clears error and reruns everything
        zero_until = nreads;
        base = nfr;
        pulse_start();
        check("seq4_error_cleared", bus.error, 1'b0);
        check("seq4_busy", bus.busy, 1'b1);
        wait_end("seq4_timeout");
        check_seq("seq4", base, 1);
        check_status("seq4_end", 1'b0, 1'b1, 1'b0, 1'b1, 8'h08);

        // Write together with start, writes during the run, ignored start
        base = nfr;
        bus.cfg_wr_en = 1'b1; bus.cfg_addr = 5'd0; bus.cfg_wr_data = 8'h5A; shadow_m[0] = 8'h5A;
        pulse_start();
        bus.cfg_wr_en = 1'b0;
        wait_frame("seq5_reach_frame2", base + 2, 1'b0);
        cfg_write(5'd5, 8'h3C);
        cfg_write(5'd20, 8'hFF);
        pulse_start();
        wait_end("seq5_timeout");
        check_seq("seq5", base, 1);
        check("seq5_frame0_data", fr_word[base][7:0], 8'h5A);
        check("seq5_frame5_data", fr_word[base + 5][7:0], 8'h3C);

        // Asynchronous reset in the middle of frame 7 while CCLK is high
        base = nfr;
        pulse_start();
        wait_frame("seq6_reach_frame7", base + 7, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_clatch_n", bus.clatch_n, 1'b1);
        check("rst_mid_cclk", bus.cclk, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) shadow_m[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_status("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("rst_mid_frame_aborted", (nfr > 0 && fr_bits[nfr - 1] < 24), 1'b1);
        base = nfr;
        pulse_start();
        wait_end("seq7_timeout");
        check_seq("seq7", base, 1);
        check("seq7_frame0", fr_word[base], 24'h08_00_00);
        check_status("seq7_end", 1'b0, 1'b1, 1'b0, 1'b1, 8'h08);

        check("pin_ordering", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
